// File: rtl/spi_reg_rdmux.sv
// Register readback port: selects one register word by address into a one-entry
// output register with valid/ready handshake, range error flag and clear-on-read pulses.
module spi_reg_rdmux #(
  parameter int                   NUM_REGS = 4,
  parameter int                   DATA_W   = 32,
  parameter int                   ADDR_W   = $clog2(NUM_REGS),
  parameter logic [NUM_REGS-1:0]  CLR_MASK = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REGS*DATA_W-1:0] reg_data_i,
  input  logic                       rd_req_i,
  input  logic [ADDR_W-1:0]          rd_addr_i,
  output logic                       rd_req_ready_o,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic                       rd_err_o,
  output logic [NUM_REGS-1:0]        clr_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // One extra bit so the range compare never aliases for non-power-of-two NUM_REGS.
  localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

  state_t              state_q;
  state_t              state_d;
  logic                accept;
  logic                complete;
  logic                in_range;
  logic [DATA_W-1:0]   sel_word;
  logic [ADDR_W-1:0]   addr_q;
  logic [NUM_REGS-1:0] clr_d;

  assign rd_valid_o     = (state_q == FULL);
  assign rd_req_ready_o = !rd_valid_o || rd_ready_i;
  assign accept         = rd_req_i && rd_req_ready_o;
  assign complete       = rd_valid_o && rd_ready_i;
  assign in_range       = ({1'b0, rd_addr_i} < REG_LIMIT);

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_i == ADDR_W'(i)) begin
        sel_word = reg_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (complete && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // The pulse refers to the result leaving on this edge, i.e. the old addr_q/rd_err_o.
  always_comb begin
    clr_d = '0;
    if (complete && !rd_err_o) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr_q == ADDR_W'(i) && CLR_MASK[i]) begin
          clr_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_data_o <= '0;
      rd_err_o  <= 1'b0;
      addr_q    <= '0;
      clr_o     <= '0;
    end else begin
      clr_o <= clr_d;
      if (accept) begin
        rd_data_o <= in_range ? sel_word : '0;
        rd_err_o  <= !in_range;
        addr_q    <= rd_addr_i;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_rdmux.sv
// Self-checking bench for spi_reg_rdmux: scoreboarded 4-register instance with
// clear-on-read on word 2, plus a 3-register instance for out-of-range reads.
module tb_spi_reg_rdmux;

  localparam logic [3:0] MASK4 = 4'b0100;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] words [4];
  logic [127:0] reg_data;
  logic        rd_req;
  logic [1:0]  rd_addr;
  logic        rd_req_ready;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_err;
  logic [3:0]  clr;

  logic [95:0] reg_data3;
  logic        rd_req3;
  logic [1:0]  rd_addr3;
  logic        rd_req_ready3;
  logic        rd_valid3;
  logic        rd_ready3;
  logic [31:0] rd_data3;
  logic        rd_err3;
  logic [2:0]  clr3;

  exp_t sb [$];
  logic m_valid;
  int   test_cnt = 0;
  int   fail_cnt = 0;

  always #5 clk = ~clk;

  assign reg_data = {words[3], words[2], words[1], words[0]};

  spi_reg_rdmux #(
    .NUM_REGS(4), .DATA_W(32), .ADDR_W(2), .CLR_MASK(MASK4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .reg_data_i(reg_data),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_req_ready_o(rd_req_ready),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .rd_err_o(rd_err), .clr_o(clr)
  );

  spi_reg_rdmux #(
    .NUM_REGS(3), .DATA_W(32), .ADDR_W(2), .CLR_MASK(3'b111)
  ) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .reg_data_i(reg_data3),
    .rd_req_i(rd_req3), .rd_addr_i(rd_addr3), .rd_req_ready_o(rd_req_ready3),
    .rd_valid_o(rd_valid3), .rd_ready_i(rd_ready3), .rd_data_o(rd_data3),
    .rd_err_o(rd_err3), .clr_o(clr3)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already driven; models the coming edge.
  task automatic apply_stimulus();
    exp_t       e;
    logic       acc;
    logic       cmp;
    logic [3:0] clr_exp;
    #1;
    check_output("req_ready", rd_req_ready, !m_valid || rd_ready);
    acc     = rd_req && (!m_valid || rd_ready);
    cmp     = m_valid && rd_ready;
    clr_exp = '0;
    if (cmp && sb.size() > 0) begin
      e = sb.pop_front();
      check_output("rd_data", rd_data, e.data);
      check_output("rd_err", rd_err, e.err);
      if (!e.err && MASK4[e.addr]) clr_exp[e.addr] = 1'b1;
    end
    if (acc) sb.push_back('{words[rd_addr], 1'b0, int'(rd_addr)});
    if (acc) m_valid = 1'b1;
    else if (cmp) m_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_output("rd_valid", rd_valid, m_valid);
    check_output("clr", clr, clr_exp);
  endtask

  task automatic edge3();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    rd_req = 1'b1;
    rd_addr = 2'd1;
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) words[i] = 32'h1111_0000 + i;
    reg_data3 = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
    rd_req3 = 1'b0;
    rd_addr3 = 2'd0;
    rd_ready3 = 1'b1;
    m_valid = 1'b0;

    // Reset held with a pending request
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd_req = 1'b0;
    #1;
    check_output("rst_valid", rd_valid, 1'b0);
    check_output("rst_data", rd_data, 32'h0);
    check_output("rst_err", rd_err, 1'b0);
    check_output("rst_clr", clr, 4'h0);
    check_output("rst_ready", rd_req_ready, 1'b1);
    check_output("rst_valid3", rd_valid3, 1'b0);

    // Single read
    words[1] = 32'hA5A5_0001;
    rd_addr = 2'd1;
    rd_req = 1'b1;
    rd_ready = 1'b1;
    apply_stimulus();
    check_output("single_data", rd_data, 32'hA5A5_0001);
    rd_req = 1'b0;
    apply_stimulus();
    check_output("single_hold", rd_data, 32'hA5A5_0001);

    // Backpressure with a second request held pending
    words[0] = 32'h0000_00C3;
    rd_addr = 2'd0;
    rd_req = 1'b1;
    rd_ready = 1'b0;
    apply_stimulus();
    words[1] = 32'h0000_5A5A;
    rd_addr = 2'd1;
    for (int i = 0; i < 5; i++) begin
      words[0] = 32'h0000_0100 + i;
      apply_stimulus();
      check_output("bp_data", rd_data, 32'h0000_00C3);
    end
    rd_ready = 1'b1;
    apply_stimulus();
    rd_req = 1'b0;
    apply_stimulus();

    // Back-to-back reads, one per cycle
    for (int i = 0; i < 4; i++) words[i] = 32'hB000_0000 + i;
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1;
      rd_addr = 2'(i);
      apply_stimulus();
    end
    rd_req = 1'b0;
    apply_stimulus();
    check_output("b2b_empty", sb.size(), 0);

    // Clear-on-read after a stall, then a non-clearing register
    words[2] = 32'hC1EA_0002;
    rd_ready = 1'b0;
    rd_req = 1'b1;
    rd_addr = 2'd2;
    apply_stimulus();
    rd_req = 1'b0;
    repeat (3) apply_stimulus();
    rd_ready = 1'b1;
    apply_stimulus();
    apply_stimulus();
    rd_req = 1'b1;
    rd_addr = 2'd1;
    apply_stimulus();
    rd_req = 1'b0;
    apply_stimulus();
    apply_stimulus();

    // Reset while holding a clear-on-read result
    rd_ready = 1'b0;
    rd_req = 1'b1;
    rd_addr = 2'd2;
    apply_stimulus();
    rd_req = 1'b0;
    rd_ready = 1'b1;
    rst_n = 1'b0;
    edge3();
    sb.delete();
    m_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check_output("midrst_valid", rd_valid, 1'b0);
    check_output("midrst_clr", clr, 4'h0);
    apply_stimulus();

    // Out-of-range on the 3-register instance
    rd_req3 = 1'b1;
    rd_addr3 = 2'd3;
    edge3();
    check_output("oor_valid", rd_valid3, 1'b1);
    check_output("oor_err", rd_err3, 1'b1);
    check_output("oor_data", rd_data3, 32'h0);
    rd_req3 = 1'b0;
    edge3();
    check_output("oor_done", rd_valid3, 1'b0);
    check_output("oor_clr", clr3, 3'b000);
    edge3();
    check_output("oor_clr2", clr3, 3'b000);
    rd_req3 = 1'b1;
    rd_addr3 = 2'd2;
    edge3();
    check_output("r3_data", rd_data3, 32'h0000_0033);
    check_output("r3_err", rd_err3, 1'b0);
    rd_req3 = 1'b0;
    edge3();
    check_output("r3_clr", clr3, 3'b100);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
